// File: rtl/uart_rx_ctrl.sv
// UART receive controller: enable gating, byte FIFO, sticky overrun
// and idle-timeout pulse counted in 16x oversample ticks.
module uart_rx_ctrl #(
    parameter int DEPTH        = 8,
    parameter int TIMEOUT_BITS = 4,
    parameter int CW           = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          b_tick,
    input  logic          rx_done,
    input  logic [7:0]    rx_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          overrun,
    input  logic          clr_overrun,
    output logic          timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_BITS * 16);
    localparam logic [TW-1:0] THR = TW'(TIMEOUT_BITS * 16 - 1);

    typedef enum logic [1:0] {IDLE, ARMED, FIRED} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt_nxt;
    logic [TW-1:0] timer, timer_nxt;
    state_t        state, state_nxt;
    logic          push_ok, pop_ok, ovr_set, to_nxt;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_data = mem[rd_ptr];

    // A pop on a full FIFO frees the slot for a same-cycle push
    assign push_ok = en & rx_done & (~full | pop);
    assign pop_ok  = pop & ~empty;
    assign ovr_set = en & rx_done & full & ~pop;
    assign cnt_nxt = count + CW'(push_ok) - CW'(pop_ok);

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        to_nxt    = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            timer_nxt = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    timer_nxt = '0;
                    if (push_ok) state_nxt = ARMED;
                end
                ARMED: begin
                    if (push_ok) begin
                        timer_nxt = '0;
                    end else if (cnt_nxt == '0) begin
                        state_nxt = IDLE;
                        timer_nxt = '0;
                    end else if (b_tick) begin
                        if (timer == THR && !empty) begin
                            to_nxt    = 1'b1;
                            timer_nxt = '0;
                            state_nxt = FIRED;
                        end else begin
                            timer_nxt = timer + 1'b1;
                        end
                    end
                end
                FIRED: begin
                    timer_nxt = '0;
                    if (push_ok) state_nxt = ARMED;
                    else if (cnt_nxt == '0) state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            timeout <= 1'b0;
            timer   <= '0;
            state   <= IDLE;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= rx_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count   <= cnt_nxt;
            // A fresh overrun beats a simultaneous clear
            overrun <= ovr_set | (overrun & ~clr_overrun);
            timeout <= to_nxt;
            timer   <= timer_nxt;
            state   <= state_nxt;
        end
    end

endmodule
